// File: rtl/commit_trace_arbiter.sv
// commit_trace_arbiter
//   Merges up to two commit ports and one exception report per cycle into a single ordered
//   trace record stream, buffers the records in a FIFO and hands them to a trace sink over a
//   valid/ready handshake. Commit cannot be stalled, so records that do not fit are dropped,
//   counted, and flagged in-band on the next accepted record.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i, debug_mode_i  tracing enable, core-in-debug (filters breakpoint exceptions)
//   commit_*_i              two commit ports, port 0 is the older instruction
//   ex_*_i                  exception report, ordered after both commit ports
//   trace_*                 head record and handshake towards the sink
//   level_o                 FIFO occupancy
//   overflow_o, drop_cnt_o  sticky drop flag and saturating drop count
module commit_trace_arbiter #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEQ_W = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_i,
   input  logic                       debug_mode_i,
   input  logic [1:0]                 commit_ack_i,
   input  logic [127:0]               commit_pc_i,
   input  logic [63:0]                commit_instr_i,
   input  logic [1:0]                 commit_we_i,
   input  logic [9:0]                 commit_waddr_i,
   input  logic [127:0]               commit_wdata_i,
   input  logic                       ex_valid_i,
   input  logic [63:0]                ex_pc_i,
   input  logic [63:0]                ex_cause_i,
   input  logic [63:0]                ex_tval_i,
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic                       trace_kind_o,
   output logic [63:0]                trace_pc_o,
   output logic [63:0]                trace_word_o,
   output logic [63:0]                trace_data_o,
   output logic [4:0]                 trace_rd_o,
   output logic                       trace_we_o,
   output logic                       trace_gap_o,
   output logic [SEQ_W-1:0]           trace_seq_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [CNT_W-1:0]           drop_cnt_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef struct packed {
      logic             kind;
      logic [63:0]      pc;
      logic [63:0]      word;
      logic [63:0]      data;
      logic [4:0]       rd;
      logic             we;
      logic             gap;
      logic [SEQ_W-1:0] seq;
   } rec_t;

   typedef enum logic [1:0] {StOff, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;
   logic             gap_q, gap_d;

   rec_t             mem_q [DEPTH];

   rec_t             raw [3];
   logic [2:0]       raw_v;
   rec_t             cand [3];
   logic [1:0]       n_cand;
   logic [1:0]       n_acc;
   logic [1:0]       n_drop;
   logic [LW-1:0]    free;
   logic             pop;
   logic [CNT_W:0]   drop_sum;
   logic [PW-1:0]    wr_idx [3];
   rec_t             head;

   // Candidate formation: raw slots in fixed priority order, then compacted so the
   // accepted set is always a prefix of cand[].
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         raw[p]      = '0;
         raw[p].kind = 1'b0;
         raw[p].pc   = commit_pc_i[64*p +: 64];
         raw[p].word = {32'd0, commit_instr_i[32*p +: 32]};
         raw[p].data = commit_wdata_i[64*p +: 64];
         raw[p].rd   = commit_waddr_i[5*p +: 5];
         raw[p].we   = commit_we_i[p];
      end
      raw[2]      = '0;
      raw[2].kind = 1'b1;
      raw[2].pc   = ex_pc_i;
      raw[2].word = ex_cause_i;
      raw[2].data = ex_tval_i;

      // Breakpoint exceptions taken in debug mode are not traced.
      raw_v[0] = commit_ack_i[0];
      raw_v[1] = commit_ack_i[1];
      raw_v[2] = ex_valid_i && !(debug_mode_i && (ex_cause_i == 64'd3));
      if (state_q != StRun) begin
         raw_v = 3'b000;
      end

      cand[0] = raw_v[0] ? raw[0] : (raw_v[1] ? raw[1] : raw[2]);
      cand[1] = (raw_v[0] && raw_v[1]) ? raw[1] : raw[2];
      cand[2] = raw[2];
      n_cand  = 2'(raw_v[0]) + 2'(raw_v[1]) + 2'(raw_v[2]);

      for (int i = 0; i < 3; i++) begin
         cand[i].seq = seq_q + SEQ_W'(i);
         cand[i].gap = 1'b0;
      end
      // Only the first accepted record of a cycle can follow an earlier gap; drops in
      // this cycle always come after every accepted record of this cycle.
      cand[0].gap = gap_q;
   end

   // Space check against occupancy at cycle start; a same-cycle pop is not credited.
   always_comb begin
      free = LW'(DEPTH) - level_q;
      if (free < LW'(n_cand)) begin
         n_acc = free[1:0];
      end else begin
         n_acc = n_cand;
      end
      n_drop = n_cand - n_acc;
      pop    = (level_q != '0) && trace_ready_i;

      for (int i = 0; i < 3; i++) begin
         wr_idx[i] = wr_ptr_q + PW'(i);
      end

      wr_ptr_d = wr_ptr_q + PW'(n_acc);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + LW'(n_acc) - LW'(pop);
      seq_d    = seq_q + SEQ_W'(n_cand);

      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(n_drop);
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      overflow_d = overflow_q || (n_drop != 2'd0);

      if (n_drop != 2'd0) begin
         gap_d = 1'b1;
      end else if (n_acc != 2'd0) begin
         gap_d = 1'b0;
      end else begin
         gap_d = gap_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StOff: begin
            if (enable_i) state_d = StRun;
         end
         StRun: begin
            if (!enable_i) state_d = StDrain;
         end
         StDrain: begin
            if (enable_i) begin
               state_d = StRun;
            end else if (level_q == '0) begin
               state_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StOff;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
         gap_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         seq_q      <= seq_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
         gap_q      <= gap_d;
      end
   end

   // Storage needs no reset: stale entries are unreachable once the pointers are cleared.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_i && (2'(i) < n_acc)) begin
            mem_q[wr_idx[i]] <= cand[i];
         end
      end
   end

   // Fields are gated with valid so an empty FIFO presents all-zero outputs.
   always_comb begin
      head          = mem_q[rd_ptr_q];
      trace_valid_o = (level_q != '0);
      trace_kind_o  = 1'b0;
      trace_pc_o    = '0;
      trace_word_o  = '0;
      trace_data_o  = '0;
      trace_rd_o    = '0;
      trace_we_o    = 1'b0;
      trace_gap_o   = 1'b0;
      trace_seq_o   = '0;
      if (trace_valid_o) begin
         trace_kind_o = head.kind;
         trace_pc_o   = head.pc;
         trace_word_o = head.word;
         trace_data_o = head.data;
         trace_rd_o   = head.rd;
         trace_we_o   = head.we;
         trace_gap_o  = head.gap;
         trace_seq_o  = head.seq;
      end
   end

   assign level_o    = level_q;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Directed self-checking bench for commit_trace_arbiter (DEPTH=8, SEQ_W=16, CNT_W=32).
module tb_commit_trace_arbiter;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          debug_mode;
   logic [1:0]    commit_ack;
   logic [127:0]  commit_pc;
   logic [63:0]   commit_instr;
   logic [1:0]    commit_we;
   logic [9:0]    commit_waddr;
   logic [127:0]  commit_wdata;
   logic          ex_valid;
   logic [63:0]   ex_pc;
   logic [63:0]   ex_cause;
   logic [63:0]   ex_tval;
   logic          trace_valid;
   logic          trace_ready;
   logic          trace_kind;
   logic [63:0]   trace_pc;
   logic [63:0]   trace_word;
   logic [63:0]   trace_data;
   logic [4:0]    trace_rd;
   logic          trace_we;
   logic          trace_gap;
   logic [15:0]   trace_seq;
   logic [3:0]    level;
   logic          overflow;
   logic [31:0]   drop_cnt;

   int n_total = 0;
   int n_pass  = 0;

   commit_trace_arbiter #(
      .DEPTH(8),
      .SEQ_W(16),
      .CNT_W(32)
   ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .debug_mode_i  (debug_mode),
      .commit_ack_i  (commit_ack),
      .commit_pc_i   (commit_pc),
      .commit_instr_i(commit_instr),
      .commit_we_i   (commit_we),
      .commit_waddr_i(commit_waddr),
      .commit_wdata_i(commit_wdata),
      .ex_valid_i    (ex_valid),
      .ex_pc_i       (ex_pc),
      .ex_cause_i    (ex_cause),
      .ex_tval_i     (ex_tval),
      .trace_valid_o (trace_valid),
      .trace_ready_i (trace_ready),
      .trace_kind_o  (trace_kind),
      .trace_pc_o    (trace_pc),
      .trace_word_o  (trace_word),
      .trace_data_o  (trace_data),
      .trace_rd_o    (trace_rd),
      .trace_we_o    (trace_we),
      .trace_gap_o   (trace_gap),
      .trace_seq_o   (trace_seq),
      .level_o       (level),
      .overflow_o    (overflow),
      .drop_cnt_o    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      commit_ack   = 2'b00;
      commit_pc    = '0;
      commit_instr = '0;
      commit_we    = 2'b00;
      commit_waddr = '0;
      commit_wdata = '0;
      ex_valid     = 1'b0;
      ex_pc        = '0;
      ex_cause     = '0;
      ex_tval      = '0;
      debug_mode   = 1'b0;
   endtask

   // Reset, then enable and step once so the block sits in RUN.
   task automatic reset_and_run();
      rst    = 1'b1;
      enable = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst    = 1'b0;
      enable = 1'b1;
      tick();
   endtask

   task automatic single_commit(input logic [63:0] pc);
      commit_ack          = 2'b01;
      commit_pc[63:0]     = pc;
      commit_instr[31:0]  = 32'h0000_0013;
   endtask

   logic [63:0] hold_pc;
   logic [15:0] hold_seq;
   logic        held;
   int          exp_seq;

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      trace_ready = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      check("reset_valid", 64'(trace_valid), 64'd0);
      check("reset_level", 64'(level), 64'd0);
      check("reset_drop", 64'(drop_cnt), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      check("reset_pc", trace_pc, 64'd0);

      // Ordering: two commits plus an exception in one cycle.
      reset_and_run();
      trace_ready          = 1'b1;
      commit_ack           = 2'b11;
      commit_pc            = {64'h8000_0004, 64'h8000_0000};
      commit_instr         = {32'h0010_0113, 32'h00a0_0093};
      commit_we            = 2'b11;
      commit_waddr         = {5'd2, 5'd1};
      commit_wdata         = {64'd1, 64'd10};
      ex_valid             = 1'b1;
      ex_pc                = 64'h8000_0008;
      ex_cause             = 64'd2;
      ex_tval              = 64'hdead_beef;
      tick();
      clear_inputs();
      check("ord_level", 64'(level), 64'd3);
      check("ord0_kind", 64'(trace_kind), 64'd0);
      check("ord0_seq", 64'(trace_seq), 64'd0);
      check("ord0_pc", trace_pc, 64'h8000_0000);
      check("ord0_word", trace_word, 64'h0000_0000_00a0_0093);
      check("ord0_data", trace_data, 64'd10);
      check("ord0_rd", 64'(trace_rd), 64'd1);
      check("ord0_gap", 64'(trace_gap), 64'd0);
      tick();
      check("ord1_kind", 64'(trace_kind), 64'd0);
      check("ord1_seq", 64'(trace_seq), 64'd1);
      check("ord1_pc", trace_pc, 64'h8000_0004);
      check("ord1_level", 64'(level), 64'd2);
      tick();
      check("ord2_kind", 64'(trace_kind), 64'd1);
      check("ord2_seq", 64'(trace_seq), 64'd2);
      check("ord2_word", trace_word, 64'd2);
      check("ord2_data", trace_data, 64'hdead_beef);
      check("ord2_rd", 64'(trace_rd), 64'd0);
      check("ord2_we", 64'(trace_we), 64'd0);
      check("ord2_gap", 64'(trace_gap), 64'd0);
      tick();
      check("ord_empty", 64'(trace_valid), 64'd0);

      // Overflow: fill with ready low, two records dropped, then drain.
      reset_and_run();
      trace_ready = 1'b0;
      commit_ack  = 2'b11;
      for (int c = 0; c < 5; c++) tick();
      clear_inputs();
      check("ovf_level", 64'(level), 64'd8);
      check("ovf_drop", 64'(drop_cnt), 64'd2);
      check("ovf_flag", 64'(overflow), 64'd1);
      trace_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("ovf_seq", 64'(trace_seq), 64'(k));
         check("ovf_gap0", 64'(trace_gap), 64'd0);
         if (k == 1) single_commit(64'h9000_0000);
         tick();
         clear_inputs();
      end
      check("ovf_gap_valid", 64'(trace_valid), 64'd1);
      check("ovf_gap_seq", 64'(trace_seq), 64'd10);
      check("ovf_gap_bit", 64'(trace_gap), 64'd1);
      check("ovf_gap_pc", trace_pc, 64'h9000_0000);
      check("ovf_drop_hold", 64'(drop_cnt), 64'd2);
      tick();
      check("ovf_empty", 64'(trace_valid), 64'd0);

      // Debug filter: breakpoint in debug mode is not traced, other causes are.
      reset_and_run();
      trace_ready = 1'b1;
      debug_mode  = 1'b1;
      ex_valid    = 1'b1;
      ex_cause    = 64'd3;
      tick();
      clear_inputs();
      check("dbg_filtered", 64'(trace_valid), 64'd0);
      single_commit(64'h100);
      tick();
      clear_inputs();
      check("dbg_seq_kept", 64'(trace_seq), 64'd0);
      tick();
      debug_mode = 1'b1;
      ex_valid   = 1'b1;
      ex_cause   = 64'd2;
      tick();
      clear_inputs();
      check("dbg_ex_valid", 64'(trace_valid), 64'd1);
      check("dbg_ex_kind", 64'(trace_kind), 64'd1);
      check("dbg_ex_seq", 64'(trace_seq), 64'd1);
      tick();

      // Drain: four records buffered, enable dropped, commits in DRAIN ignored.
      reset_and_run();
      trace_ready = 1'b0;
      commit_ack  = 2'b11;
      tick();
      tick();
      clear_inputs();
      check("drn_level", 64'(level), 64'd4);
      enable = 1'b0;
      tick();
      trace_ready = 1'b1;
      commit_ack  = 2'b11;
      for (int k = 0; k < 4; k++) begin
         check("drn_seq", 64'(trace_seq), 64'(k));
         tick();
      end
      clear_inputs();
      check("drn_empty", 64'(trace_valid), 64'd0);
      check("drn_drop", 64'(drop_cnt), 64'd0);
      tick();
      tick();
      enable = 1'b1;
      tick();
      single_commit(64'h200);
      tick();
      clear_inputs();
      check("drn_seq_resume", 64'(trace_seq), 64'd4);
      tick();

      // Back-pressure: ready toggles each cycle over a 20-commit burst.
      reset_and_run();
      exp_seq = 0;
      held    = 1'b0;
      begin
         int sent;
         sent = 0;
         for (int c = 0; c < 50; c++) begin
            clear_inputs();
            trace_ready = c[0];
            if (c[0] && sent < 20) begin
               single_commit(64'h1000 + 64'(4 * sent));
               sent++;
            end
            if (held) begin
               check("bp_hold_pc", trace_pc, hold_pc);
               check("bp_hold_seq", 64'(trace_seq), 64'(hold_seq));
            end
            held = 1'b0;
            if (trace_valid && trace_ready) begin
               check("bp_seq", 64'(trace_seq), 64'(exp_seq));
               check("bp_pc", trace_pc, 64'h1000 + 64'(4 * exp_seq));
               exp_seq++;
            end else if (trace_valid) begin
               held     = 1'b1;
               hold_pc  = trace_pc;
               hold_seq = trace_seq;
            end
            tick();
         end
      end
      clear_inputs();
      check("bp_count", 64'(exp_seq), 64'd20);
      check("bp_drop", 64'(drop_cnt), 64'd0);

      // Reset mid-stream discards buffered records.
      reset_and_run();
      trace_ready = 1'b0;
      commit_ack  = 2'b11;
      tick();
      tick();
      commit_ack = 2'b01;
      tick();
      clear_inputs();
      check("rms_level5", 64'(level), 64'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rms_valid", 64'(trace_valid), 64'd0);
      check("rms_level", 64'(level), 64'd0);
      check("rms_drop", 64'(drop_cnt), 64'd0);
      tick();
      single_commit(64'h300);
      tick();
      clear_inputs();
      check("rms_new_valid", 64'(trace_valid), 64'd1);
      check("rms_new_seq", 64'(trace_seq), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
